jtoutrun_roadbuf: RTL and testbench

Double-buffered road RAM for the Out Run video board. It sits between the sub CPU bus (road_cs, sub_addr, sub_dout, sub_dswn) and the road line renderer inside the video path. The sub CPU writes a 2K-word CPU bank. A control-register read arms a swap request. At the next vertical blank the block copies the CPU bank into the render bank with a sequencer, so the renderer sees a stable frame and the CPU keeps its data.

---
 rtl/jtoutrun_roadbuf_pkg.sv | 11 +
 rtl/jtframe_dual_ram16.sv | 33 +++
 rtl/jtoutrun_roadbuf_copy.sv | 87 ++++++++
 rtl/jtoutrun_roadbuf.sv | 92 +++++++++
 tb/tb_jtoutrun_roadbuf.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtoutrun_roadbuf_pkg.sv
// Shared constants and FSM encoding for the Out Run road double buffer.
package jtoutrun_roadbuf_pkg;
  localparam int          ROAD_AW       = 11;
  localparam int          ROAD_CTRL_W   = 3;
  localparam logic [15:0] CTRL_RD_VALUE = 16'hFFFF;

  typedef enum logic {
    IDLE = 1'b0,
    COPY = 1'b1
  } copy_state_t;
endpackage

// File: rtl/jtframe_dual_ram16.sv
// 16-bit dual-port RAM: port 0 read/write with byte enables, port 1 read-only.
module jtframe_dual_ram16 #(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] i_addr0,
  input  logic [15:0]   i_data0,
  input  logic [1:0]    i_we0,
  output logic [15:0]   o_q0,
  input  logic [AW-1:0] i_addr1,
  output logic [15:0]   o_q1
);
  logic [15:0] r_mem [2**AW];
  logic [15:0] r_q0;
  logic [15:0] r_q1;

  // Read-first: a same-cycle write is seen by the next read only.
  always_ff @(posedge clk) begin
    if (i_we0[0]) r_mem[i_addr0][7:0]  <= i_data0[7:0];
    if (i_we0[1]) r_mem[i_addr0][15:8] <= i_data0[15:8];
    if (rst) begin
      r_q0 <= 16'd0;
      r_q1 <= 16'd0;
    end else begin
      r_q0 <= r_mem[i_addr0];
      r_q1 <= r_mem[i_addr1];
    end
  end

  assign o_q0 = r_q0;
  assign o_q1 = r_q1;
endmodule

// File: rtl/jtoutrun_roadbuf_copy.sv
// Swap arming, vblank detection and the bank-copy sequencer (read at cnt, write at cnt_d).
module jtoutrun_roadbuf_copy
  import jtoutrun_roadbuf_pkg::*;
#(
  parameter int AW = ROAD_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_lvbl,
  input  logic          i_ctrl_rd,
  output logic [AW-1:0] o_src_addr,
  output logic          o_dst_we,
  output logic [AW-1:0] o_dst_addr,
  output logic          o_busy,
  output logic          o_pending,
  output copy_state_t   o_state
);
  localparam logic [AW-1:0] CNT_LAST = '1;

  copy_state_t   r_state;
  logic          r_lvbl_l;
  logic          r_ctrl_rd_l;
  logic          r_pending;
  logic          r_busy;
  logic          r_flush;
  logic          r_we;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] r_cnt_d;
  logic          w_vbl_fall;
  logic          w_ctrl_rise;

  assign w_vbl_fall  = r_lvbl_l & ~i_lvbl;
  assign w_ctrl_rise = i_ctrl_rd & ~r_ctrl_rd_l;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_lvbl_l    <= 1'b0;
      r_ctrl_rd_l <= 1'b0;
      r_pending   <= 1'b0;
      r_busy      <= 1'b0;
      r_flush     <= 1'b0;
      r_we        <= 1'b0;
      r_cnt       <= '0;
      r_cnt_d     <= '0;
    end else begin
      r_lvbl_l    <= i_lvbl;
      r_ctrl_rd_l <= i_ctrl_rd;
      case (r_state)
        IDLE: begin
          r_we    <= 1'b0;
          r_flush <= 1'b0;
          if (r_pending && w_vbl_fall) begin
            r_state   <= COPY;
            r_busy    <= 1'b1;
            r_pending <= 1'b0;
            r_cnt     <= '0;
          end
        end
        COPY: begin
          r_cnt_d <= r_cnt;
          // The flush cycle only commits the word read on the last count.
          if (r_flush) begin
            r_we    <= 1'b0;
            r_flush <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_we <= 1'b1;
            if (r_cnt == CNT_LAST) r_flush <= 1'b1;
            else                   r_cnt   <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
      // A control read re-arms even mid-copy, scheduling the following vblank.
      if (w_ctrl_rise) r_pending <= 1'b1;
    end
  end

  assign o_src_addr = r_cnt;
  assign o_dst_we   = r_we;
  assign o_dst_addr = r_cnt_d;
  assign o_busy     = r_busy;
  assign o_pending  = r_pending;
  assign o_state    = r_state;
endmodule

// File: rtl/jtoutrun_roadbuf.sv
// Double-buffered road RAM: CPU bank copied into the render bank during an armed vblank.
module jtoutrun_roadbuf
  import jtoutrun_roadbuf_pkg::*;
#(
  parameter int AW = ROAD_AW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   LVBL,
  input  logic [AW-1:0]          cpu_addr,
  input  logic [15:0]            cpu_dout,
  input  logic [1:0]             cpu_dswn,
  input  logic                   ram_cs,
  input  logic                   ctrl_cs,
  output logic [15:0]            road_dout,
  output logic [ROAD_CTRL_W-1:0] road_ctrl,
  input  logic [AW-1:0]          rd_addr,
  output logic [15:0]            rd_data,
  output logic                   busy,
  output logic                   pending
);
  logic                   w_ctrl_rd;
  logic [1:0]             w_ram_we;
  logic [15:0]            w_cpu_q;
  logic [15:0]            w_src_q;
  logic [AW-1:0]          w_src_addr;
  logic                   w_dst_we;
  logic [AW-1:0]          w_dst_addr;
  logic [15:0]            w_unused_dst_q;
  copy_state_t            w_unused_state;
  logic                   r_ram_rd;
  logic                   r_ctrl_rd;
  logic [15:0]            r_hold;
  logic [ROAD_CTRL_W-1:0] r_ctrl;

  assign w_ctrl_rd = ctrl_cs & (cpu_dswn == 2'b11);
  assign w_ram_we  = {2{ram_cs}} & ~cpu_dswn;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ram_rd  <= 1'b0;
      r_ctrl_rd <= 1'b0;
      r_hold    <= 16'd0;
      r_ctrl    <= '0;
    end else begin
      r_ram_rd  <= ram_cs;
      r_ctrl_rd <= w_ctrl_rd;
      r_hold    <= road_dout;
      if (ctrl_cs && !cpu_dswn[0]) r_ctrl <= cpu_dout[ROAD_CTRL_W-1:0];
    end
  end

  // The bank output is already registered; r_hold keeps the bus stable between accesses.
  assign road_dout = r_ram_rd  ? w_cpu_q :
                     r_ctrl_rd ? CTRL_RD_VALUE : r_hold;
  assign road_ctrl = r_ctrl;

  jtoutrun_roadbuf_copy #(.AW(AW)) u_copy (
    .clk        (clk),
    .rst        (rst),
    .i_lvbl     (LVBL),
    .i_ctrl_rd  (w_ctrl_rd),
    .o_src_addr (w_src_addr),
    .o_dst_we   (w_dst_we),
    .o_dst_addr (w_dst_addr),
    .o_busy     (busy),
    .o_pending  (pending),
    .o_state    (w_unused_state)
  );

  jtframe_dual_ram16 #(.AW(AW)) u_cpu_bank (
    .clk     (clk),
    .rst     (rst),
    .i_addr0 (cpu_addr),
    .i_data0 (cpu_dout),
    .i_we0   (w_ram_we),
    .o_q0    (w_cpu_q),
    .i_addr1 (w_src_addr),
    .o_q1    (w_src_q)
  );

  jtframe_dual_ram16 #(.AW(AW)) u_render_bank (
    .clk     (clk),
    .rst     (rst),
    .i_addr0 (w_dst_addr),
    .i_data0 (w_src_q),
    .i_we0   ({2{w_dst_we}}),
    .o_q0    (w_unused_dst_q),
    .i_addr1 (rd_addr),
    .o_q1    (rd_data)
  );
endmodule

// File: tb/tb_jtoutrun_roadbuf.sv
// Scoreboard bench for jtoutrun_roadbuf against an array-based model of both banks.
module tb_jtoutrun_roadbuf;
  localparam int AW = 11;
  localparam int N  = 2048;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          LVBL = 1'b1;
  logic [AW-1:0] cpu_addr = '0;
  logic [15:0]   cpu_dout = '0;
  logic [1:0]    cpu_dswn = 2'b11;
  logic          ram_cs = 1'b0;
  logic          ctrl_cs = 1'b0;
  logic [15:0]   road_dout;
  logic [2:0]    road_ctrl;
  logic [AW-1:0] rd_addr = '0;
  logic [15:0]   rd_data;
  logic          busy;
  logic          pending;

  jtoutrun_roadbuf #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .LVBL(LVBL), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_dswn(cpu_dswn), .ram_cs(ram_cs), .ctrl_cs(ctrl_cs), .road_dout(road_dout),
    .road_ctrl(road_ctrl), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .pending(pending)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state
  logic [15:0] cpu_m     [N];
  logic [15:0] rend_m    [N];
  logic [15:0] rend_next [N];
  logic [2:0]  m_ctrl = 3'd0;
  logic        m_pending = 1'b0;
  bit          copy_active = 1'b0;
  int          copy_read = 0;
  int          busy_cycles = 0;

  // scoreboard
  logic [15:0] exp_q  [$];
  logic [15:0] rexp_q [$];
  logic        rchk_en = 1'b0;
  logic        mon_rd = 1'b0;
  logic        mon_rr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    mon_rd = !rst && (ram_cs || ctrl_cs) && (cpu_dswn == 2'b11);
    mon_rr = !rst && rchk_en;
  end

  always @(negedge clk) begin
    if (busy) busy_cycles++;
    if (mon_rd) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL road_dout_unexpected actual=%0h required=none", road_dout);
      end else chk("road_dout", road_dout, exp_q.pop_front());
    end
    if (mon_rr) begin
      if (rexp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_data_unexpected actual=%0h required=none", rd_data);
      end else chk("rd_data", rd_data, rexp_q.pop_front());
    end
  end

  // drivers
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic bus_idle();
    step();
    ram_cs = 1'b0; ctrl_cs = 1'b0; cpu_dswn = 2'b11;
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] dswn);
    step();
    ram_cs = 1'b1; ctrl_cs = 1'b0; cpu_addr = a; cpu_dout = d; cpu_dswn = dswn;
    if (!dswn[0]) cpu_m[a][7:0]  = d[7:0];
    if (!dswn[1]) cpu_m[a][15:8] = d[15:8];
    if (copy_active && int'(a) >= copy_read) rend_next[a] = cpu_m[a];
  endtask

  task automatic cpu_read(input logic [AW-1:0] a);
    step();
    ram_cs = 1'b1; ctrl_cs = 1'b0; cpu_addr = a; cpu_dswn = 2'b11;
    exp_q.push_back(cpu_m[a]);
  endtask

  task automatic ctrl_write(input logic [15:0] d, input logic [1:0] dswn);
    step();
    ram_cs = 1'b0; ctrl_cs = 1'b1; cpu_dout = d; cpu_dswn = dswn;
    if (!dswn[0]) m_ctrl = d[2:0];
  endtask

  task automatic ctrl_read();
    step();
    ram_cs = 1'b0; ctrl_cs = 1'b1; cpu_dswn = 2'b11;
    exp_q.push_back(16'hFFFF);
    m_pending = 1'b1;
  endtask

  task automatic scan_render();
    for (int a = 0; a < N; a++) begin
      step();
      rd_addr = AW'(a);
      rchk_en = 1'b1;
      rexp_q.push_back(rend_m[a]);
    end
    step();
    rchk_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // mode 0: plain copy, 1: CPU writes mid-copy, 2: control read then reset mid-copy
  task automatic vblank(input int mode, input bit expect_copy);
    bit done;
    bit acted;
    bus_idle();
    LVBL = 1'b0;
    if (expect_copy) begin
      rend_next   = cpu_m;
      copy_active = 1'b1;
      copy_read   = 0;
      m_pending   = 1'b0;
    end
    busy_cycles = 0;
    @(posedge clk);
    @(negedge clk); #1;
    chk("busy_rise", {31'd0, busy}, {31'd0, expect_copy});
    chk("pending_after_vbl", {31'd0, pending}, {31'd0, m_pending});
    if (!expect_copy) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk); #1;
        chk("busy_no_copy", {31'd0, busy}, 32'd0);
      end
      LVBL = 1'b1;
      return;
    end
    done  = 1'b0;
    acted = 1'b0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      copy_read = busy_cycles + 1;
      if (cyc == 50) LVBL = 1'b1;
      if (busy_cycles == 1000 && mode != 0 && !acted) begin
        acted = 1'b1;
        if (mode == 1) begin
          cpu_write(AW'(0), 16'hC0DE, 2'b00);
          cpu_write(AW'(N-1), 16'hBEEF, 2'b00);
          bus_idle();
        end else begin
          ctrl_read();
          bus_idle();
          @(negedge clk); #1;
          chk("pending_rearm_in_copy", {31'd0, pending}, {31'd0, m_pending});
          step();
          rst = 1'b1;
          @(posedge clk);
          @(negedge clk); #1;
          m_pending = 1'b0;
          m_ctrl    = 3'd0;
          chk("rst_busy", {31'd0, busy}, 32'd0);
          chk("rst_pending", {31'd0, pending}, {31'd0, m_pending});
          chk("rst_road_ctrl", {29'd0, road_ctrl}, {29'd0, m_ctrl});
          chk("rst_road_dout", {16'd0, road_dout}, 32'd0);
          chk("rst_rd_data", {16'd0, rd_data}, 32'd0);
          rst = 1'b0;
          LVBL = 1'b1;
        end
      end
      @(negedge clk); #1;
      if (!busy) done = 1'b1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL copy_timeout actual=%0d required=%0d", busy_cycles, N + 1);
    end
    LVBL = 1'b1;
    copy_active = 1'b0;
    if (mode != 2) begin
      chk("busy_length", busy_cycles, N + 1);
      rend_m = rend_next;
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin cpu_m[i] = 16'd0; rend_m[i] = 16'd0; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    chk("reset_road_dout", {16'd0, road_dout}, 32'd0);
    chk("reset_road_ctrl", {29'd0, road_ctrl}, 32'd0);
    chk("reset_rd_data", {16'd0, rd_data}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_pending", {31'd0, pending}, 32'd0);

    // byte-lane merge at address 5
    cpu_write(AW'(5), 16'h1234, 2'b00);
    cpu_write(AW'(5), 16'h77AB, 2'b10);
    cpu_read(AW'(5));
    bus_idle();
    @(negedge clk); #1;
    chk("model_merge", {16'd0, cpu_m[5]}, 32'h12AB);

    // control register: lower lane only
    ctrl_write(16'h0005, 2'b10);
    bus_idle();
    @(negedge clk); #1;
    chk("road_ctrl_lower", {29'd0, road_ctrl}, {29'd0, m_ctrl});
    ctrl_write(16'h0002, 2'b01);
    bus_idle();
    @(negedge clk); #1;
    chk("road_ctrl_upper_ignored", {29'd0, road_ctrl}, {29'd0, m_ctrl});

    // fill and first armed copy
    for (int a = 0; a < N; a++) cpu_write(AW'(a), 16'(a) ^ 16'h5A5A, 2'b00);
    ctrl_read();
    bus_idle();
    @(negedge clk); #1;
    chk("pending_armed", {31'd0, pending}, {31'd0, m_pending});
    vblank(0, 1'b1);
    scan_render();

    // random CPU traffic, then an unarmed vblank leaves the render bank alone
    repeat (300) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, N - 1));
      case ($urandom_range(0, 3))
        0: cpu_write(a, 16'($urandom), 2'b00);
        1: cpu_write(a, 16'($urandom), 2'b01);
        2: cpu_write(a, 16'($urandom), 2'b10);
        default: cpu_read(a);
      endcase
    end
    bus_idle();
    vblank(0, 1'b0);
    scan_render();

    // two arms, one copy; writes landing mid-copy
    ctrl_read();
    bus_idle();
    ctrl_read();
    bus_idle();
    vblank(1, 1'b1);
    scan_render();
    vblank(0, 1'b0);
    ctrl_read();
    bus_idle();
    vblank(0, 1'b1);
    scan_render();

    // reset during copy, then a full fresh copy
    ctrl_write(16'h0003, 2'b00);
    ctrl_read();
    bus_idle();
    vblank(2, 1'b1);
    ctrl_read();
    bus_idle();
    vblank(0, 1'b1);
    scan_render();
    @(negedge clk); #1;
    chk("final_road_ctrl", {29'd0, road_ctrl}, {29'd0, m_ctrl});

    repeat (4) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 32'd0);
    chk("rexp_q_drained", rexp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
